// File: rtl/guide_pkg.sv
// guide_pkg: shared definitions for the truth-table scanner slice.
//   state_t        - scanner FSM state encoding (IDLE, HOLD, SAMPLE, DONE)
//   DEFAULT_N_IN   - default number of function inputs
//   DEFAULT_SETTLE - default settle cycles per vector
//   SETTLE_W       - width of the settle counter (settle range 0..15)
package guide_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_N_IN   = 4;
  localparam int DEFAULT_SETTLE = 1;
  localparam int SETTLE_W       = 4;

endpackage

// File: rtl/scan_counter.sv
// scan_counter: vector index plus per-vector settle counter.
//   clk, reset   - clock, asynchronous active-high reset
//   load         - start of scan: index=0, settle counter=SETTLE
//   hold         - FSM is in HOLD; settle counter counts down to 0
//   advance      - step to the next vector and reload the settle counter
//   index        - current input vector
//   last_vector  - index is all-ones (final vector of the table)
//   sample_now   - in HOLD with the settle counter exhausted
module scan_counter
  import guide_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            hold,
  input  logic            advance,
  output logic [N_IN-1:0] index,
  output logic            last_vector,
  output logic            sample_now
);

  logic [SETTLE_W-1:0] settle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index      <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      index      <= '0;
      settle_cnt <= SETTLE_W'(SETTLE);
    end else if (advance) begin
      index      <= index + N_IN'(1);
      settle_cnt <= SETTLE_W'(SETTLE);
    end else if (hold && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SETTLE_W'(1);
    end
  end

  // Termination is decided on the all-ones index before any increment,
  // so the index never wraps.
  assign last_vector = &index;
  assign sample_now  = hold && (settle_cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives every input vector of an N_IN-input
// combinational function in ascending order, waits SETTLE cycles per vector,
// captures the single output F into a truth table and compares it against
// an expected table latched at start.
//   clk, reset  - clock, asynchronous active-high reset
//   start       - begin a scan (honoured only in IDLE)
//   expected    - expected table, bit i = F for vector i; latched on start
//   dut_in      - vector driven to the function, MSB is input A
//   dut_f       - function output F
//   busy        - HOLD or SAMPLE in progress
//   done        - one-cycle pulse after the final sample
//   table_out   - captured table, bit i = F sampled for vector i
//   mismatch    - any captured bit differed from expected
//   err_count   - number of differing bits (0..2**N_IN)
//   first_err   - lowest differing vector index, 0 when none
//   state_dbg   - current FSM state for observation
//
// Handshake: start is a level sampled on the rising edge; it is accepted only
// when state_dbg==IDLE, otherwise it is dropped (no queuing). Results are
// valid from the done pulse until the next accepted start.
module truth_table_scanner
  import guide_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err,
  output state_t               state_dbg
);

  localparam int DEPTH = 2**N_IN;

  state_t            state, state_nxt;
  logic              accept;
  logic              in_hold, in_sample;
  logic [N_IN-1:0]   index;
  logic              last_vector, sample_now;
  logic [DEPTH-1:0]  exp_lat;

  assign accept    = (state == IDLE) && start;
  assign in_hold   = (state == HOLD);
  assign in_sample = (state == SAMPLE);
  assign state_dbg = state;

  scan_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_scan_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .hold        (in_hold),
    .advance     (in_sample && !last_vector),
    .index       (index),
    .last_vector (last_vector),
    .sample_now  (sample_now)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dut_in    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HOLD;
      end
      HOLD: begin
        busy   = 1'b1;
        dut_in = index;
        if (sample_now) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy   = 1'b1;
        dut_in = index;
        state_nxt = last_vector ? DONE : HOLD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture and compare. first_err is only written while mismatch is still
  // clear, so it keeps the lowest failing index (vectors run ascending).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_lat   <= '0;
      table_out <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      first_err <= '0;
    end else if (accept) begin
      exp_lat   <= expected;
      table_out <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      first_err <= '0;
    end else if (in_sample) begin
      table_out[index] <= dut_f;
      if (dut_f != exp_lat[index]) begin
        err_count <= err_count + (N_IN+1)'(1);
        mismatch  <= 1'b1;
        if (!mismatch) first_err <= index;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench for truth_table_scanner.
// Three instances: default (SETTLE=1, combinational model), SETTLE=3 and
// SETTLE=0 (both with a 3-cycle delayed model). Drivers push the hand-computed
// result of each scan into a per-instance queue; monitors pop on done.
module tb_truth_table_scanner;
  import guide_pkg::*;

  localparam int W = 34; // {table[15:0], mismatch, err[4:0], first[3:0], latency[7:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_seen = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q3[$];
  logic [W-1:0] exp_qz[$];

  logic [15:0] exp_in = '0;
  logic [15:0] tt0 = '0;
  logic [15:0] tt_dly = 16'h1894;

  // default instance
  logic start0 = 1'b0;
  logic [3:0] dut_in0;
  logic dut_f0, busy0, done0, mm0;
  logic [15:0] tbl0;
  logic [4:0] err0;
  logic [3:0] first0;
  state_t st0;
  assign dut_f0 = tt0[dut_in0];

  truth_table_scanner u_dut (
    .clk(clk), .reset(reset), .start(start0), .expected(exp_in),
    .dut_in(dut_in0), .dut_f(dut_f0), .busy(busy0), .done(done0),
    .table_out(tbl0), .mismatch(mm0), .err_count(err0), .first_err(first0),
    .state_dbg(st0)
  );

  // SETTLE=3 instance with a delayed model
  logic start3 = 1'b0;
  logic [3:0] dut_in3, d3_1, d3_2, d3_3;
  logic dut_f3, busy3, done3, mm3;
  logic [15:0] tbl3;
  logic [4:0] err3;
  logic [3:0] first3;
  state_t st3;
  assign dut_f3 = tt_dly[d3_3];

  truth_table_scanner #(.N_IN(4), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .reset(reset), .start(start3), .expected(exp_in),
    .dut_in(dut_in3), .dut_f(dut_f3), .busy(busy3), .done(done3),
    .table_out(tbl3), .mismatch(mm3), .err_count(err3), .first_err(first3),
    .state_dbg(st3)
  );

  // SETTLE=0 instance with the same delayed model
  logic startz = 1'b0;
  logic [3:0] dut_inz, dz_1, dz_2, dz_3;
  logic dut_fz, busyz, donez, mmz;
  logic [15:0] tblz;
  logic [4:0] errz;
  logic [3:0] firstz;
  state_t stz;
  assign dut_fz = tt_dly[dz_3];

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(startz), .expected(exp_in),
    .dut_in(dut_inz), .dut_f(dut_fz), .busy(busyz), .done(donez),
    .table_out(tblz), .mismatch(mmz), .err_count(errz), .first_err(firstz),
    .state_dbg(stz)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      d3_1 <= '0; d3_2 <= '0; d3_3 <= '0;
      dz_1 <= '0; dz_2 <= '0; dz_3 <= '0;
    end else begin
      d3_1 <= dut_in3; d3_2 <= d3_1; d3_3 <= d3_2;
      dz_1 <= dut_inz; dz_2 <= dz_1; dz_3 <= dz_2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [15:0] tbl, input logic mm,
                                      input logic [4:0] err, input logic [3:0] first,
                                      input logic [7:0] lat);
    return {tbl, mm, err, first, lat};
  endfunction

  task automatic score(input string name, input logic [W-1:0] e,
                       input logic [15:0] tbl, input logic mm, input logic [4:0] err,
                       input logic [3:0] first, input int lat);
    check({name, ".table_out"}, 32'(tbl),   32'(e[33:18]));
    check({name, ".mismatch"},  32'(mm),    32'(e[17]));
    check({name, ".err_count"}, 32'(err),   32'(e[16:12]));
    check({name, ".first_err"}, 32'(first), 32'(e[11:8]));
    check({name, ".latency"},   32'(lat),   32'(e[7:0]));
  endtask

  // Monitors: one per instance, pop on every done pulse.
  initial forever begin
    @(negedge clk);
    if (done0) begin
      if (exp_q0.size() == 0) check("dut0.unexpected_done", 32'd1, 32'd0);
      else score("dut0", exp_q0.pop_front(), tbl0, mm0, err0, first0, cyc - t0);
      done_seen++;
    end
    if (done3) begin
      if (exp_q3.size() == 0) check("dut_s3.unexpected_done", 32'd1, 32'd0);
      else score("dut_s3", exp_q3.pop_front(), tbl3, mm3, err3, first3, cyc - t0);
      done_seen++;
    end
    if (donez) begin
      if (exp_qz.size() == 0) check("dut_s0.unexpected_done", 32'd1, 32'd0);
      else score("dut_s0", exp_qz.pop_front(), tblz, mmz, errz, firstz, cyc - t0);
      done_seen++;
    end
  end

  // t0 is the cycle in which start is presented; done seen in cycle t0+L
  // means done appeared L cycles after the accepting edge.
  task automatic issue_start(input int which, input logic [15:0] e);
    @(negedge clk);
    exp_in = e;
    t0 = cyc;
    case (which)
      0: start0 = 1'b1;
      3: start3 = 1'b1;
      default: startz = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start3 = 1'b0; startz = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_seen;
    n = 0;
    while (done_seen == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == base) check({name, ".timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("reset.dut_in",    32'(dut_in0), 32'd0);
    check("reset.busy",      32'(busy0),   32'd0);
    check("reset.done",      32'(done0),   32'd0);
    check("reset.table_out", 32'(tbl0),    32'd0);
    check("reset.mismatch",  32'(mm0),     32'd0);
    check("reset.err_count", 32'(err0),    32'd0);
    check("reset.first_err", 32'(first0),  32'd0);
    check("reset.state",     32'(st0),     32'(IDLE));

    // correct function
    tt0 = 16'h1894;
    exp_q0.push_back(mk(16'h1894, 1'b0, 5'd0, 4'd0, 8'd49));
    issue_start(0, 16'h1894);
    check("scan_a.busy_cycle1", 32'(busy0), 32'd1);
    check("scan_a.dut_in_cycle1", 32'(dut_in0), 32'd0);
    wait_done("scan_a");

    // single fault at vector 1
    exp_q0.push_back(mk(16'h1894, 1'b1, 5'd1, 4'd1, 8'd49));
    issue_start(0, 16'h1896);
    wait_done("scan_b");

    // all bits wrong
    tt0 = 16'h0000;
    exp_q0.push_back(mk(16'h0000, 1'b1, 5'd16, 4'd0, 8'd49));
    issue_start(0, 16'hFFFF);
    wait_done("scan_c");

    // start re-pulsed at cycle 10 with a different expected: ignored
    tt0 = 16'h1894;
    exp_q0.push_back(mk(16'h1894, 1'b0, 5'd0, 4'd0, 8'd49));
    issue_start(0, 16'h1894);
    exp_in = 16'h0000;
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done("scan_d");

    // reset at cycle 20 of a failing scan: immediate clear, no done
    base = done_seen;
    issue_start(0, 16'hFFFF);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort.busy",      32'(busy0),  32'd0);
    check("abort.dut_in",    32'(dut_in0), 32'd0);
    check("abort.table_out", 32'(tbl0),   32'd0);
    check("abort.err_count", 32'(err0),   32'd0);
    check("abort.mismatch",  32'(mm0),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("abort.no_done", 32'(done_seen - base), 32'd0);

    // normal scan after reset
    exp_q0.push_back(mk(16'h1894, 1'b0, 5'd0, 4'd0, 8'd49));
    issue_start(0, 16'h1894);
    wait_done("scan_f");

    // SETTLE=3 with a 3-cycle delayed function: clean, 81 cycles
    exp_q3.push_back(mk(16'h1894, 1'b0, 5'd0, 4'd0, 8'd81));
    issue_start(3, 16'h1894);
    wait_done("scan_s3");

    // SETTLE=0 with the same model: each sample sees vector v-1,
    // captured = 16'h3128, diff 16'h29BC -> 8 errors, first at 2
    exp_qz.push_back(mk(16'h3128, 1'b1, 5'd8, 4'd2, 8'd33));
    issue_start(1, 16'h1894);
    wait_done("scan_s0");

    repeat (5) @(negedge clk);
    check("leftover.q0", 32'(exp_q0.size()), 32'd0);
    check("leftover.q3", 32'(exp_q3.size()), 32'd0);
    check("leftover.qz", 32'(exp_qz.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus-and-capture engine for the Guide 11 N-input combinational logic blocks (NOR/NAND-only function realisations).
- Drives every input combination in ascending order into a combinational function-under-test and waits a programmable settle time.
- Samples the function's single output into a truth-table register and compares each bit against an expected table.
- Sits beside each function block as the hardware replacement for the hand-written exhaustive $display benches.

Parameters:
- N_IN, 4, number of function inputs; table depth is 2**N_IN.
- SETTLE, 1, cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; honoured only in IDLE.
- expected  input  2**N_IN  expected truth table; bit i is F for input vector i; sampled once, on the accepted start.
- dut_in  output  N_IN  vector driven to the function; MSB is A, e.g. {A,B,C,D}.
- dut_f  input  1  function output F.
- busy  output  1  high from the cycle after start is accepted through the last sample.
- done  output  1  one-cycle pulse after the final sample.
- table_out  output  2**N_IN  captured truth table; bit i is F sampled for vector i.
- mismatch  output  1  high if any captured bit differs from expected; valid from done until the next accepted start.
- err_count  output  N_IN+1  number of differing bits, 0..2**N_IN.
- first_err  output  N_IN  lowest vector index that differed; 0 when mismatch=0.

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs are 0: dut_in, busy, done, table_out, mismatch, err_count, first_err.
  - The internal index, settle counter and expected latch are cleared.
- IDLE:
  - start=1 latches expected, clears table_out, err_count, mismatch and first_err, sets index=0 and settle counter=SETTLE, then moves to HOLD.
  - start=0 keeps the previous results stable.
- HOLD:
  - dut_in = index; busy=1.
  - When the settle counter is non-zero, decrement it.
  - When it is 0, go to SAMPLE. With SETTLE=0, HOLD lasts exactly 1 cycle.
  - Each vector therefore occupies SETTLE+1 cycles of HOLD plus 1 cycle of SAMPLE.
- SAMPLE (1 cycle):
  - table_out[index] <= dut_f.
  - If dut_f != expected[index]: err_count increments; mismatch <= 1; first_err <= index on the first mismatch only.
  - If index is at its maximum, go to DONE; otherwise index+1, reload the settle counter, and return to HOLD.
  - dut_in stays at index during SAMPLE.
- DONE (1 cycle): done=1, busy=0, dut_in returns to 0, then IDLE.
- Scan latency, from the accepted start edge to the done pulse: 2**N_IN*(SETTLE+2)+1 cycles. With the defaults this is 49.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously restarts a scan every time IDLE is re-entered.
- Changes on expected after the accepted start have no effect.
- Index wrap is impossible. The index counter is N_IN bits wide, and termination is decided on index==all-ones before any increment.
- err_count is N_IN+1 bits so an all-bits-wrong result (2**N_IN) is representable without overflow.
- Reset asserted mid-scan aborts immediately and produces no done pulse. Partial results are discarded (cleared to 0).

Decomposition:
- A shared package guide_pkg holds the state enum {IDLE, HOLD, SAMPLE, DONE} and the default N_IN/SETTLE constants.
- One natural sub-module, scan_counter: the index plus settle counter, exposing last_vector and sample_now strobes.
- The FSM and the compare/accumulate logic stay in the top module.

Test Plan:
- Correct function, default parameters:
  - Stimulus: bench model F = lookup(16'h1894, dut_in), expected=16'h1894, start pulse.
  - Response: done exactly 49 cycles after the start edge; table_out=16'h1894, mismatch=0, err_count=0, first_err=0.
- Single fault:
  - Stimulus: same model, expected=16'h1896.
  - Response: table_out=16'h1894, mismatch=1, err_count=1, first_err=1.
- All bits wrong:
  - Stimulus: model F = lookup(16'h0000), expected=16'hFFFF.
  - Response: err_count=16 (5'b10000), first_err=0.
- Settle timing, SETTLE=3:
  - Stimulus: model with a 3-cycle delayed output; expected=16'h1894.
  - Response: no mismatch; scan length 16*5+1=81 cycles.
  - With SETTLE=0 and the same delayed model, mismatch must be 1.
- Handshake and reset:
  - Stimulus: start re-pulsed at cycle 10 of a scan.
  - Response: ignored, and done arrives at cycle 49 as normal.
  - Stimulus: reset asserted at cycle 20 of a new scan.
  - Response: within the same cycle busy=0, dut_in=0, table_out=0, and done never pulses.
  - After reset, a new start completes normally.
